// File: rtl/bf_result_checker.sv
// Sweeps result vs golden distance memory after a Bellman-Ford run; folds in the negative-cycle verdict.
// Latency: DEPTH+1 cycles from the start edge to done on a sweep, 2 cycles on the negative-cycle path.
// Backpressure: none; start is ignored while busy, and the verdict is held until the next accepted start.
module bf_result_checker #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 13,
    parameter int DEPTH  = 8192,
    parameter int CNT_W  = 14
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              neg_cycle,
    input  logic              expect_neg,
    output logic [ADDR_W-1:0] OMAR,
    input  logic [DATA_W-1:0] OMDR,
    output logic [ADDR_W-1:0] GMAR,
    input  logic [DATA_W-1:0] GMDR,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  mismatch_cnt,
    output logic [CNT_W-1:0]  unreach_cnt,
    output logic [ADDR_W-1:0] first_bad_addr,
    output logic              first_bad_valid
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_NEG  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [1:0] state;
    // A start seen in IDLE/DONE is held here for one cycle; the run launches on the following
    // edge, which is also where done drops and busy rises.
    logic       launch;
    logic       neg_q;
    logic       exp_q;

    logic word_bad;
    logic word_unreach;
    logic at_last;
    logic mis_full;
    logic unr_full;

    // Per-word classification of the entry currently addressed.
    always_comb begin
        word_bad     = (OMDR != GMDR);
        word_unreach = &OMDR;
        at_last      = (OMAR == LAST_ADDR);
        mis_full     = &mismatch_cnt;
        unr_full     = &unreach_cnt;
    end

    // Golden memory is always read at the same address as the result memory.
    assign GMAR = OMAR;

    // Control FSM, sweep address, counters and verdict registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= S_IDLE;
            launch          <= 1'b0;
            neg_q           <= 1'b0;
            exp_q           <= 1'b0;
            OMAR            <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            mismatch_cnt    <= '0;
            unreach_cnt     <= '0;
            first_bad_addr  <= '1;
            first_bad_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (launch) begin
                        launch          <= 1'b0;
                        mismatch_cnt    <= '0;
                        unreach_cnt     <= '0;
                        first_bad_addr  <= '1;
                        first_bad_valid <= 1'b0;
                        pass            <= 1'b0;
                        done            <= 1'b0;
                        busy            <= 1'b1;
                        OMAR            <= '0;
                        state           <= (neg_q || exp_q) ? S_NEG : S_SCAN;
                    end else if (start) begin
                        launch <= 1'b1;
                        neg_q  <= neg_cycle;
                        exp_q  <= expect_neg;
                    end
                end
                S_NEG: begin
                    // Negative cycle on either side: the memories are meaningless, only flags compare.
                    pass         <= (neg_q == exp_q);
                    mismatch_cnt <= (neg_q == exp_q) ? '0 : CNT_W'(1);
                    busy         <= 1'b0;
                    done         <= 1'b1;
                    state        <= S_DONE;
                end
                S_SCAN: begin
                    if (word_bad) begin
                        if (!mis_full) begin
                            mismatch_cnt <= mismatch_cnt + CNT_W'(1);
                        end
                        if (!first_bad_valid) begin
                            first_bad_addr  <= OMAR;
                            first_bad_valid <= 1'b1;
                        end
                    end
                    if (word_unreach && !unr_full) begin
                        unreach_cnt <= unreach_cnt + CNT_W'(1);
                    end
                    if (at_last) begin
                        // Verdict from the sticky flag, since the counter may have saturated.
                        pass  <= !(first_bad_valid || word_bad);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        OMAR  <= '0;
                        state <= S_DONE;
                    end else begin
                        OMAR <= OMAR + ADDR_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bf_result_checker.sv
// Self-checking bench for bf_result_checker with DEPTH=8, CNT_W=2.
// Table vectors push expected verdicts to a queue; a monitor pops them when done rises.
// Hand sequences cover reset mid-sweep, mid-sweep start and a held start.
module tb_bf_result_checker;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 13;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              neg_cycle = 1'b0;
    logic              expect_neg = 1'b0;
    logic [ADDR_W-1:0] OMAR;
    logic [DATA_W-1:0] OMDR;
    logic [ADDR_W-1:0] GMAR;
    logic [DATA_W-1:0] GMDR;
    logic              busy;
    logic              done;
    logic              pass;
    logic [CNT_W-1:0]  mismatch_cnt;
    logic [CNT_W-1:0]  unreach_cnt;
    logic [ADDR_W-1:0] first_bad_addr;
    logic              first_bad_valid;

    logic [7:0][15:0] res_mem = '0;
    logic [7:0][15:0] gold_mem = '0;

    bf_result_checker #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .neg_cycle(neg_cycle), .expect_neg(expect_neg),
        .OMAR(OMAR), .OMDR(OMDR), .GMAR(GMAR), .GMDR(GMDR),
        .busy(busy), .done(done), .pass(pass),
        .mismatch_cnt(mismatch_cnt), .unreach_cnt(unreach_cnt),
        .first_bad_addr(first_bad_addr), .first_bad_valid(first_bad_valid)
    );

    always #5 clock = ~clock;

    always_comb begin
        OMDR = (OMAR < ADDR_W'(8)) ? res_mem[OMAR[2:0]] : 16'h0000;
        GMDR = (GMAR < ADDR_W'(8)) ? gold_mem[GMAR[2:0]] : 16'h0000;
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [7:0][15:0] res;
        logic [7:0][15:0] gold;
        logic             nc;
        logic             en;
        logic             e_pass;
        int               e_mis;
        int               e_unr;
        int               e_fba;
        logic             e_fbv;
    } vec_t;

    typedef struct {
        int   done_cyc;
        int   busy_cyc;
        int   max_addr;
        logic pass;
        int   mis;
        int   unr;
        int   fba;
        logic fbv;
    } exp_t;

    vec_t tbl[8];
    exp_t q[$];

    task automatic setv(input int i, input logic [7:0][15:0] r, input logic [7:0][15:0] g,
                        input logic nc, input logic en, input logic p, input int mis,
                        input int unr, input int fba, input logic fbv);
        tbl[i].res = r;     tbl[i].gold = g;
        tbl[i].nc = nc;     tbl[i].en = en;
        tbl[i].e_pass = p;  tbl[i].e_mis = mis;
        tbl[i].e_unr = unr; tbl[i].e_fba = fba;
        tbl[i].e_fbv = fbv;
    endtask

    function automatic exp_t mk_exp(input int i, input int done_cyc);
        exp_t e;
        int   lat;
        lat        = (tbl[i].nc || tbl[i].en) ? 2 : DEPTH + 1;
        e.done_cyc = done_cyc + lat;
        e.busy_cyc = (lat == 2) ? 1 : DEPTH;
        e.max_addr = (lat == 2) ? 0 : DEPTH - 1;
        e.pass     = tbl[i].e_pass;
        e.mis      = tbl[i].e_mis;
        e.unr      = tbl[i].e_unr;
        e.fba      = tbl[i].e_fba;
        e.fbv      = tbl[i].e_fbv;
        return e;
    endfunction

    // Monitor: tracks activity during a run and scores the verdict when done rises.
    int   busy_n = 0;
    int   max_a = 0;
    int   gmar_bad = 0;
    logic done_prev = 1'b0;
    always @(negedge clock) begin
        if (reset) begin
            busy_n    = 0;
            max_a     = 0;
            done_prev = 1'b0;
        end else begin
            if (busy) busy_n++;
            if (int'(OMAR) > max_a) max_a = int'(OMAR);
            if (GMAR !== OMAR) gmar_bad++;
            if (done && !done_prev) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("busy_cycles", busy_n, e.busy_cyc);
                    chk("max_addr", max_a, e.max_addr);
                    chk("pass", int'(pass), int'(e.pass));
                    chk("mismatch_cnt", int'(mismatch_cnt), e.mis);
                    chk("unreach_cnt", int'(unreach_cnt), e.unr);
                    chk("first_bad_addr", int'(first_bad_addr), e.fba);
                    chk("first_bad_valid", int'(first_bad_valid), int'(e.fbv));
                end
                busy_n = 0;
                max_a  = 0;
            end
            done_prev = done;
        end
    end

    task automatic wait_drain(input int max_cyc);
        for (int k = 0; k < max_cyc && q.size() != 0; k++) @(negedge clock);
        chk("drain_timeout", q.size(), 0);
        q.delete();
    endtask

    task automatic load(input int i);
        res_mem    = tbl[i].res;
        gold_mem   = tbl[i].gold;
        neg_cycle  = tbl[i].nc;
        expect_neg = tbl[i].en;
    endtask

    task automatic run_vec(input int i, input bit mid_pulse);
        @(negedge clock);
        load(i);
        start = 1'b1;
        q.push_back(mk_exp(i, cyc + 1));
        @(negedge clock);
        start      = 1'b0;
        neg_cycle  = 1'b0;
        expect_neg = 1'b0;
        if (mid_pulse) begin
            repeat (3) @(negedge clock);
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
        end
        wait_drain(40);
    endtask

    initial begin
        logic [7:0][15:0] base;
        logic [7:0][15:0] r;
        logic [7:0][15:0] g;
        int n;

        base = {16'h000C, 16'h000B, 16'h000A, 16'h0009,
                16'h0003, 16'hFFFF, 16'h0005, 16'h0000};
        setv(0, base, base, 1'b0, 1'b0, 1'b1, 0, 1, 'h1FFF, 1'b0);
        r = base; g = base;
        r[3] = 16'h0007; g[3] = 16'h0008;
        r[6] = 16'hFFFF; g[6] = 16'h0002;
        setv(1, r, g, 1'b0, 1'b0, 1'b0, 2, 2, 3, 1'b1);
        setv(2, base, base, 1'b1, 1'b1, 1'b1, 0, 0, 'h1FFF, 1'b0);
        setv(3, base, base, 1'b1, 1'b0, 1'b0, 1, 0, 'h1FFF, 1'b0);
        setv(4, base, base, 1'b0, 1'b1, 1'b0, 1, 0, 'h1FFF, 1'b0);
        r = '1; g = '0;
        setv(5, r, g, 1'b0, 1'b0, 1'b0, 3, 3, 0, 1'b1);
        r = base; r[7] = 16'h000D;
        setv(6, r, base, 1'b0, 1'b0, 1'b0, 1, 1, 7, 1'b1);
        r = base; g = base;
        r[0] = 16'hFFFF; g[0] = 16'hFFFE;
        setv(7, r, g, 1'b0, 1'b0, 1'b0, 1, 2, 0, 1'b1);

        // Reset values.
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_mis", int'(mismatch_cnt), 0);
        chk("rst_unr", int'(unreach_cnt), 0);
        chk("rst_fba", int'(first_bad_addr), 'h1FFF);
        chk("rst_fbv", int'(first_bad_valid), 0);
        chk("rst_omar", int'(OMAR), 0);
        chk("rst_gmar", int'(GMAR), 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(i, 1'b0);

        // Start pulsed mid-sweep must not disturb latency or results.
        run_vec(1, 1'b1);

        // Reset at sweep address 4: everything back to reset values, no verdict afterwards.
        @(negedge clock);
        load(0);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (OMAR != ADDR_W'(4) && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("reach_addr4", int'(OMAR), 4);
        reset = 1'b1;
        @(negedge clock);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_pass", int'(pass), 0);
        chk("mid_rst_mis", int'(mismatch_cnt), 0);
        chk("mid_rst_unr", int'(unreach_cnt), 0);
        chk("mid_rst_fba", int'(first_bad_addr), 'h1FFF);
        chk("mid_rst_fbv", int'(first_bad_valid), 0);
        chk("mid_rst_omar", int'(OMAR), 0);
        chk("mid_rst_gmar", int'(GMAR), 0);
        reset = 1'b0;
        repeat (12) @(negedge clock);
        chk("no_partial_done", int'(done), 0);
        run_vec(0, 1'b0);

        // Start held high across DONE: exactly one new sweep per DONE entry.
        @(negedge clock);
        load(0);
        start = 1'b1;
        q.push_back(mk_exp(0, cyc + 1));
        q.push_back(mk_exp(0, cyc + 11));
        repeat (12) @(negedge clock);
        start = 1'b0;
        wait_drain(40);
        repeat (15) @(negedge clock);
        chk("held_done_stays", int'(done), 1);
        chk("held_pass_stays", int'(pass), 1);

        chk("gmar_equals_omar", gmar_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
